impartitor_8_4_secvential: RTL and testbench
============================================

Name: impartitor_8_4_secvential

Overview:
- Sequential restoring divider. It is the inverse of the 4-bit multiplier: it divides an 8-bit value (the range of a 4x4 product) by a 4-bit divisor.
- Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock, under a start/done handshake.
- Sits in the lab arithmetic set. The bench reuses the multiplier's vectors to check that (a*b)/b == a.

Parameters:
- N_DEIMPARTIT, 8, dividend and quotient width.
- N_IMPARTITOR, 4, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- deimpartit  input  8  dividend; captured on accepted start.
- impartitor  input  4  divisor; captured on accepted start.
- cat  output  8  quotient; held until next accepted start.
- rest  output  4  remainder; held until next accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when cat/rest become valid.
- div_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset, sampled at a clk edge with rst=1: state=IDLE, cat=0, rest=0, busy=0, done=0, div_zero=0, step counter=0. rst overrides everything, including mid-operation; the aborted operation produces no done.
- States are IDLE, BUSY and DONE.
  - IDLE: if start=1, the operands are captured at the edge (edge 0).
  - Divisor nonzero: go to BUSY, busy=1, working remainder R(5b)=0, Q=dividend, counter=0.
  - Divisor zero: go directly to DONE at edge 0, with cat=8'hFF, rest=4'h0, div_zero=1, done=1.
- BUSY step, one per edge:
  - R' = {R[3:0], Q[7]}; Q' = {Q[6:0], 0}.
  - If R' >= {0, divisor} then R' -= divisor and Q'[0] = 1.
  - Counter increments each step.
- BUSY completion: the 8th step happens at edge 8. At that edge the state goes to DONE, cat=Q', rest=R'[3:0], div_zero=0, busy=0, done=1.
- Latency: done is high in the cycle after edge 8 (8 cycles after start) for a nonzero divisor. For a zero divisor it is high in the cycle after edge 0 (1 cycle).
- DONE lasts exactly one cycle, then IDLE. start=1 during DONE is accepted exactly as in IDLE, so back-to-back operations work and done pulses once per operation.
- start during BUSY is ignored. Operand inputs are don't-care outside the accepting edge.
- Results are invariant: cat*divisor + rest == dividend and rest < divisor, with cat taken as unsigned 8 bits.
- cat and rest keep their previous values during BUSY. They update only at the transition into DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package impartitor_pkg holds:
  - state encoding, 2-bit (IDLE=0, BUSY=1, DONE=2);
  - width constants N_DEIMPARTIT and N_IMPARTITOR;
  - step count PASI=8 and counter width 4.
- One combinational sub-module, pas_impartire. It performs a single restoring step (inputs R, Q, divisor; outputs R', Q'). The top instantiates it once and contains the FSM, counter and output registers.

Test Plan:
- Reset, then 6/2, 20/4, 21/3, 225/15 (the multiplier products): cat = 3, 5, 7, 15 and rest = 0. Each done pulses exactly 8 cycles after start, and busy is high for those 8 cycles.
- Edge values, 255/1 -> 255 r0, 7/15 -> 0 r7, 0/5 -> 0 r0, 200/7 -> 28 r4: cat/rest match, and the invariant is checked for an exhaustive sweep of all 256x15 nonzero pairs.
- 9/0 -> done one cycle after start, cat=8'hFF, rest=0, div_zero=1. A subsequent 9/3 -> cat=3, rest=0, div_zero=0.
- start with 100/9, then start with 50/5 pulsed at cycle 3 of BUSY: the second start is ignored and the result is 11 r1 at the original done time.
- start asserted during the DONE cycle with 64/8: the next result is 8 r0 with done 8 cycles later. There must be no idle gap, and done must be two separate one-cycle pulses.
- rst asserted at cycle 4 of BUSY: the next cycle shows state IDLE, all outputs 0, and no done pulse. A fresh 30/4 then gives 7 r2.

Source files
------------

// File: rtl/impartitor_pkg.sv
// Shared types and constants for the sequential 8/4 restoring divider.
// Holds the FSM encoding, operand widths and the step count.
package impartitor_pkg;

    localparam int N_DEIMPARTIT = 8;
    localparam int N_IMPARTITOR = 4;
    localparam int PASI         = 8;
    localparam int N_CNT        = 4;

    // Counter value during the final restoring step
    localparam logic [N_CNT-1:0] CNT_ULTIM = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stare_t;

endpackage

// File: rtl/pas_impartire.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits and record a quotient 1.
module pas_impartire
    import impartitor_pkg::*;
(
    input  logic [N_IMPARTITOR:0]   r_s,
    input  logic [N_DEIMPARTIT-1:0] q_s,
    input  logic [N_IMPARTITOR-1:0] divisor_s,
    output logic [N_IMPARTITOR:0]   r_next_s,
    output logic [N_DEIMPARTIT-1:0] q_next_s
);

    logic [N_IMPARTITOR:0] shift_s;
    logic [N_IMPARTITOR:0] div_ext_s;

    // Shift, compare and conditionally restore
    always_comb begin
        shift_s   = {r_s[N_IMPARTITOR-1:0], q_s[N_DEIMPARTIT-1]};
        div_ext_s = {1'b0, divisor_s};
        if (shift_s >= div_ext_s) begin
            r_next_s = shift_s - div_ext_s;
            q_next_s = {q_s[N_DEIMPARTIT-2:0], 1'b1};
        end else begin
            r_next_s = shift_s;
            q_next_s = {q_s[N_DEIMPARTIT-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/impartitor_8_4_secvential.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient
// bit per clock, start/done handshake, results held until the next start.
module impartitor_8_4_secvential
    import impartitor_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_DEIMPARTIT-1:0] deimpartit,
    input  logic [N_IMPARTITOR-1:0] impartitor,
    output logic [N_DEIMPARTIT-1:0] cat,
    output logic [N_IMPARTITOR-1:0] rest,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero
);

    stare_t                  stare_r, stare_next_s;
    logic [N_IMPARTITOR:0]   r_r, r_next_s, r_step_s;
    logic [N_DEIMPARTIT-1:0] q_r, q_next_s, q_step_s;
    logic [N_IMPARTITOR-1:0] d_r, d_next_s;
    logic [N_CNT-1:0]        cnt_r, cnt_next_s;
    logic [N_DEIMPARTIT-1:0] cat_r, cat_next_s;
    logic [N_IMPARTITOR-1:0] rest_r, rest_next_s;
    logic                    busy_r, busy_next_s;
    logic                    done_r, done_next_s;
    logic                    div_zero_r, div_zero_next_s;

    pas_impartire u_pas (
        .r_s       (r_r),
        .q_s       (q_r),
        .divisor_s (d_r),
        .r_next_s  (r_step_s),
        .q_next_s  (q_step_s)
    );

    // Next-state and next-output logic for the divider FSM
    always_comb begin
        stare_next_s    = stare_r;
        r_next_s        = r_r;
        q_next_s        = q_r;
        d_next_s        = d_r;
        cnt_next_s      = cnt_r;
        cat_next_s      = cat_r;
        rest_next_s     = rest_r;
        busy_next_s     = 1'b0;
        done_next_s     = 1'b0;
        div_zero_next_s = div_zero_r;
        case (stare_r)
            IDLE, DONE: begin
                // DONE accepts a new start just like IDLE, so operations chain
                if (start) begin
                    d_next_s = impartitor;
                    if (impartitor == {N_IMPARTITOR{1'b0}}) begin
                        stare_next_s    = DONE;
                        cat_next_s      = {N_DEIMPARTIT{1'b1}};
                        rest_next_s     = {N_IMPARTITOR{1'b0}};
                        div_zero_next_s = 1'b1;
                        done_next_s     = 1'b1;
                    end else begin
                        stare_next_s = BUSY;
                        busy_next_s  = 1'b1;
                        r_next_s     = {(N_IMPARTITOR+1){1'b0}};
                        q_next_s     = deimpartit;
                        cnt_next_s   = {N_CNT{1'b0}};
                    end
                end else begin
                    stare_next_s = IDLE;
                end
            end
            BUSY: begin
                r_next_s   = r_step_s;
                q_next_s   = q_step_s;
                cnt_next_s = cnt_r + 4'd1;
                if (cnt_r == CNT_ULTIM) begin
                    stare_next_s    = DONE;
                    cat_next_s      = q_step_s;
                    rest_next_s     = r_step_s[N_IMPARTITOR-1:0];
                    div_zero_next_s = 1'b0;
                    done_next_s     = 1'b1;
                end else begin
                    busy_next_s = 1'b1;
                end
            end
            default: begin
                stare_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stare_r    <= IDLE;
            r_r        <= {(N_IMPARTITOR+1){1'b0}};
            q_r        <= {N_DEIMPARTIT{1'b0}};
            d_r        <= {N_IMPARTITOR{1'b0}};
            cnt_r      <= {N_CNT{1'b0}};
            cat_r      <= {N_DEIMPARTIT{1'b0}};
            rest_r     <= {N_IMPARTITOR{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            stare_r    <= stare_next_s;
            r_r        <= r_next_s;
            q_r        <= q_next_s;
            d_r        <= d_next_s;
            cnt_r      <= cnt_next_s;
            cat_r      <= cat_next_s;
            rest_r     <= rest_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            div_zero_r <= div_zero_next_s;
        end
    end

    assign cat      = cat_r;
    assign rest     = rest_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_impartitor_8_4_secvential.sv
// Scoreboard bench for the sequential divider: a driver pushes the expected
// quotient/remainder and done cycle; a monitor pops and compares on each done.
module tb_impartitor_8_4_secvential;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] deimpartit;
    logic [3:0] impartitor;
    logic [7:0] cat;
    logic [3:0] rest;
    logic       busy;
    logic       done;
    logic       div_zero;

    impartitor_8_4_secvential dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .deimpartit (deimpartit),
        .impartitor (impartitor),
        .cat        (cat),
        .rest       (rest),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;

    // Cycle index: value seen at a negedge equals the number of the last posedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    // Monitor: busy window every cycle, result comparison on each done pulse
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected no pulse", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_time", 32'(cyc), 32'(e.at));
                    chk("cat", 32'(cat), 32'(e.q));
                    chk("rest", 32'(rest), 32'(e.r));
                    chk("div_zero", 32'(div_zero), 32'(e.dz));
                    if (e.b != 0) begin
                        chk("invariant", 32'(int'(cat) * e.b + int'(rest)), 32'(e.a));
                        chk("rest_lt_div", 32'(int'(rest) < e.b), 32'd1);
                    end
                end
            end
        end
    end

    // Reference model from the arithmetic definition of division
    task automatic issue(input int a, input int b);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.q  = (b != 0) ? a / b : 255;
        e.r  = (b != 0) ? a % b : 0;
        e.dz = (b == 0) ? 1 : 0;
        e.at = (b != 0) ? cyc + 9 : cyc + 1;
        if (b != 0) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + 8;
        end
        sb.push_back(e);
        deimpartit = a[7:0];
        impartitor = b[3:0];
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        deimpartit = 8'($urandom);
        impartitor = 4'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout at cycle %0d: got no done expected a pulse", cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        busy_lo = 1;
        busy_hi = 0;
        chk("rst_cat", 32'(cat), 32'd0);
        chk("rst_rest", 32'(rest), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;
    endtask

    task automatic single(input int a, input int b);
        issue(a, b);
        wait_done();
        @(negedge clk);
    endtask

    int pa[8] = '{6, 20, 21, 225, 255, 7, 0, 200};
    int pb[8] = '{2, 4, 3, 15, 1, 15, 5, 7};

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        deimpartit = 8'd0;
        impartitor = 4'd0;
        @(negedge clk);
        do_reset();

        // Multiplier products and edge values
        for (int i = 0; i < 8; i++) single(pa[i], pb[i]);

        // Zero divisor, then a normal operation started in the DONE cycle
        issue(9, 0);
        wait_done();
        issue(9, 3);
        wait_done();
        @(negedge clk);

        // start during BUSY must be ignored
        issue(100, 9);
        repeat (2) @(negedge clk);
        deimpartit = 8'd50;
        impartitor = 4'd5;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done();
        @(negedge clk);

        // Back-to-back: second start in the DONE cycle
        issue(21, 3);
        wait_done();
        issue(64, 8);
        wait_done();
        @(negedge clk);

        // Reset in the middle of an operation aborts it without done
        issue(200, 7);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        single(30, 4);

        // Random operations, including zero divisors, chained or with gaps
        for (int i = 0; i < 200; i++) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            wait_done();
            if ($urandom_range(0, 1) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
        @(negedge clk);

        // Exhaustive sweep of nonzero divisors, fully chained
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(a, b);
                wait_done();
            end
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
